// File: rtl/insn_pkg.sv
// Shared encoding constants for the vector instruction encoder: bundle format
// enum, vset* selector codes, major-opcode values and field bit positions.
// The opcode_legal() helper is only referenced when INSN_ENC_CHECK_EN is defined.
package insn_pkg;

  typedef enum logic [1:0] {
    FmtAlu     = 2'd0,
    FmtMem     = 2'd1,
    FmtCfg     = 2'd2,
    FmtIllegal = 2'd3
  } fmt_e;

  // cfg_type codes; 2'b0x selects vsetvli
  localparam logic [1:0] CfgVsetvl   = 2'b10;
  localparam logic [1:0] CfgVsetivli = 2'b11;

  localparam logic [6:0] OpcV       = 7'h57;
  localparam logic [6:0] OpcLoadFp  = 7'h07;
  localparam logic [6:0] OpcStoreFp = 7'h27;

  localparam int unsigned EncWidth = 32;

  // Field LSB positions inside the encoded word
  localparam int unsigned PosOpcMjr = 0;
  localparam int unsigned PosDest   = 7;
  localparam int unsigned PosMnr    = 12;
  localparam int unsigned PosSrc1   = 15;
  localparam int unsigned PosSrc2   = 20;
  localparam int unsigned PosVm     = 25;
  localparam int unsigned PosFunct6 = 26;
  localparam int unsigned PosMop    = 26;
  localparam int unsigned PosMew    = 28;
  localparam int unsigned PosNf     = 29;
  localparam int unsigned PosZimm   = 20;
  localparam int unsigned PosIvliHi = 30;
  localparam int unsigned PosVlHi   = 25;

  localparam logic [2:0] CfgMnr   = 3'b111;
  localparam logic [1:0] IvliHi   = 2'b11;
  localparam logic [6:0] VsetvlHi = 7'b1000000;

  // Major opcode allowed for each format
  function automatic logic opcode_legal(fmt_e f, logic [6:0] mjr);
    logic ok;
    ok = 1'b0;
    unique case (f)
      FmtAlu, FmtCfg: ok = (mjr == OpcV);
      FmtMem:         ok = (mjr == OpcLoadFp) || (mjr == OpcStoreFp);
      FmtIllegal:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/insn_fifo.sv
// Instruction-word queue with a registered head output. The head register is
// loaded with the next head value each cycle, so rdata never depends on the
// memory read path and holds its last value once the queue drains.
module insn_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_nxt  = rd_ptr_q + AW'(1);
  assign count   = count_q;
  assign rdata   = head_q;

  // Occupancy and next head value
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
    // Incoming word becomes head if the queue is (or is about to be) empty
    if (do_push && (empty || (do_pop && count_q == CW'(1)))) begin
      head_d = wdata;
    end else if (do_pop && count_q > CW'(1)) begin
      head_d = mem_q[rd_nxt];
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_nxt;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/insn_encoder.sv
// Vector instruction encoder: packs an ALU / MEM / CFG field bundle into a
// 32-bit instruction word and queues it in insn_fifo. Rejected bundles are
// dropped and flagged by a one-cycle registered err pulse.
// Optional build macro: INSN_ENC_CHECK_EN also rejects bundles whose major
// opcode does not match their format.
module insn_encoder
  import insn_pkg::*;
#(
  parameter int unsigned INSN_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              fmt,
  input  logic [6:0]              opcode_mjr,
  input  logic [2:0]              opcode_mnr,
  input  logic [4:0]              dest,
  input  logic [4:0]              src_1,
  input  logic [4:0]              src_2,
  input  logic                    vm,
  input  logic [5:0]              funct6,
  input  logic [2:0]              width,
  input  logic [1:0]              mop,
  input  logic                    mew,
  input  logic [2:0]              nf,
  input  logic [10:0]             zimm_11,
  input  logic [9:0]              zimm_10,
  input  logic [1:0]              cfg_type,
  output logic [INSN_WIDTH-1:0]   insn_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err
);

  logic [EncWidth-1:0] word;
  logic                illegal, accept, push, full, empty, err_q;

  // Pack fields by format; fmt=3 is flagged illegal
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    word[PosOpcMjr +: 7] = opcode_mjr;
    word[PosDest +: 5]   = dest;
    word[PosSrc1 +: 5]   = src_1;
    unique case (fmt_e'(fmt))
      FmtAlu: begin
        word[PosMnr +: 3]    = opcode_mnr;
        word[PosSrc2 +: 5]   = src_2;
        word[PosVm]          = vm;
        word[PosFunct6 +: 6] = funct6;
      end
      FmtMem: begin
        word[PosMnr +: 3]  = width;
        word[PosSrc2 +: 5] = src_2;
        word[PosVm]        = vm;
        word[PosMop +: 2]  = mop;
        word[PosMew]       = mew;
        word[PosNf +: 3]   = nf;
      end
      FmtCfg: begin
        word[PosMnr +: 3] = CfgMnr;
        if (cfg_type == CfgVsetivli) begin
          word[PosZimm +: 10]  = zimm_10;
          word[PosIvliHi +: 2] = IvliHi;
        end else if (cfg_type == CfgVsetvl) begin
          word[PosSrc2 +: 5]  = src_2;
          word[PosVlHi +: 7]  = VsetvlHi;
        end else begin
          // vsetvli: bit 31 stays 0
          word[PosZimm +: 11] = zimm_11;
        end
      end
      FmtIllegal: begin
        illegal = 1'b1;
      end
    endcase
`ifdef INSN_ENC_CHECK_EN
    if (!opcode_legal(fmt_e'(fmt), opcode_mjr)) begin
      illegal = 1'b1;
    end
`endif
  end

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !illegal;
  assign out_valid = !empty;
  assign err       = err_q;

  // One-cycle error pulse for each accepted-but-rejected bundle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && illegal;
    end
  end

  insn_fifo #(
    .WIDTH (INSN_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (INSN_WIDTH'(word)),
    .pop   (out_ready),
    .rdata (insn_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder: fixed encoding vectors, hand-written
// full / reject / streaming / mid-stream reset sequences, then random traffic
// against a queue-based reference model.
module tb_insn_encoder;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [1:0]  fmt;
    logic [6:0]  mjr;
    logic [2:0]  mnr;
    logic [4:0]  dest;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        vm;
    logic [5:0]  f6;
    logic [2:0]  width;
    logic [1:0]  mop;
    logic        mew;
    logic [2:0]  nf;
    logic [10:0] z11;
    logic [9:0]  z10;
    logic [1:0]  ct;
  } bundle_t;

  typedef struct {
    bundle_t     b;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [31:0] insn_out;
  logic [2:0]  count;
  bundle_t     cur;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] mq[$];
  logic [31:0] exp_out;
  logic        exp_err;

  always #5 clk = ~clk;

  insn_encoder #(
    .INSN_WIDTH (32),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (cur.fmt),
    .opcode_mjr (cur.mjr),
    .opcode_mnr (cur.mnr),
    .dest       (cur.dest),
    .src_1      (cur.s1),
    .src_2      (cur.s2),
    .vm         (cur.vm),
    .funct6     (cur.f6),
    .width      (cur.width),
    .mop        (cur.mop),
    .mew        (cur.mew),
    .nf         (cur.nf),
    .zimm_11    (cur.z11),
    .zimm_10    (cur.z10),
    .cfg_type   (cur.ct),
    .insn_out   (insn_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .err        (err)
  );

  function automatic bundle_t mk(logic [1:0] fmt, logic [6:0] mjr, logic [2:0] mnr,
                                 logic [4:0] dest, logic [4:0] s1, logic [4:0] s2,
                                 logic vm, logic [5:0] f6, logic [2:0] width,
                                 logic [1:0] mop, logic mew, logic [2:0] nf,
                                 logic [10:0] z11, logic [9:0] z10, logic [1:0] ct);
    bundle_t b;
    b.fmt = fmt; b.mjr = mjr; b.mnr = mnr; b.dest = dest; b.s1 = s1; b.s2 = s2;
    b.vm = vm; b.f6 = f6; b.width = width; b.mop = mop; b.mew = mew; b.nf = nf;
    b.z11 = z11; b.z10 = z10; b.ct = ct;
    return b;
  endfunction

  function automatic bundle_t rand_bundle(logic [1:0] fmt, int mjr_sel);
    bundle_t b;
    b = mk(fmt, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           1'($urandom), 6'($urandom), 3'($urandom), 2'($urandom), 1'($urandom),
           3'($urandom), 11'($urandom), 10'($urandom), 2'($urandom));
    case (mjr_sel)
      0: b.mjr = 7'h57;
      1: b.mjr = 7'h07;
      2: b.mjr = 7'h27;
      default: ;
    endcase
    return b;
  endfunction

  // Reference encoding straight from the field layout tables
  function automatic logic [31:0] ref_enc(bundle_t b);
    case (b.fmt)
      2'd0: return {b.f6, b.vm, b.s2, b.s1, b.mnr, b.dest, b.mjr};
      2'd1: return {b.nf, b.mew, b.mop, b.vm, b.s2, b.s1, b.width, b.dest, b.mjr};
      2'd2: begin
        if (b.ct == 2'b11)      return {2'b11, b.z10, b.s1, 3'b111, b.dest, b.mjr};
        else if (b.ct == 2'b10) return {7'b1000000, b.s2, b.s1, 3'b111, b.dest, b.mjr};
        else                    return {1'b0, b.z11, b.s1, 3'b111, b.dest, b.mjr};
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_illegal(bundle_t b);
    logic ill;
    ill = (b.fmt == 2'd3);
`ifdef INSN_ENC_CHECK_EN
    if ((b.fmt == 2'd0 || b.fmt == 2'd2) && b.mjr != 7'h57) ill = 1'b1;
    if (b.fmt == 2'd1 && b.mjr != 7'h07 && b.mjr != 7'h27) ill = 1'b1;
`endif
    return ill;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() != DEPTH));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".insn_out"}, insn_out, exp_out);
  endtask

  // One clock: predict from current inputs, advance, compare everything
  task automatic cycle(input string tag);
    logic        acc, pop, ill;
    logic [31:0] w;
    acc = in_valid && (mq.size() != DEPTH);
    pop = out_ready && (mq.size() != 0);
    ill = ref_illegal(cur);
    w   = ref_enc(cur);
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (acc && !ill) mq.push_back(w);
    exp_err = acc && ill;
    if (mq.size() != 0) exp_out = mq[0];
    check_all(tag);
  endtask

  vec_t        vecs[8];
  logic [31:0] pushed[4];

  initial begin
    vecs[0].b = mk(2'd0, 7'h57, 3'd0, 5'd1, 5'd3, 5'd2, 1'b1, 6'h00, 3'd0, 2'd0, 1'b0,
                   3'd0, 11'h000, 10'h000, 2'd0);
    vecs[0].exp = 32'h022180D7;
    vecs[1].b = mk(2'd2, 7'h57, 3'd2, 5'd5, 5'd10, 5'd0, 1'b0, 6'h00, 3'd0, 2'd0, 1'b0,
                   3'd0, 11'h010, 10'h000, 2'd0);
    vecs[1].exp = 32'h010572D7;
    vecs[2].b = mk(2'd2, 7'h57, 3'd0, 5'd7, 5'd4, 5'd0, 1'b0, 6'h00, 3'd0, 2'd0, 1'b0,
                   3'd0, 11'h5AA, 10'h0C3, 2'd3);
    vecs[2].exp = 32'hCC3273D7;
    vecs[3].b = mk(2'd2, 7'h57, 3'd5, 5'd6, 5'd8, 5'd9, 1'b1, 6'h15, 3'd0, 2'd0, 1'b0,
                   3'd0, 11'h7FF, 10'h3FF, 2'd2);
    vecs[3].exp = 32'h80947357;
    vecs[4].b = mk(2'd1, 7'h07, 3'd5, 5'd12, 5'd2, 5'd5, 1'b1, 6'h3F, 3'd6, 2'd1, 1'b0,
                   3'd2, 11'h000, 10'h000, 2'd0);
    vecs[4].exp = 32'h46516607;
    vecs[5].b = mk(2'd0, 7'h57, 3'd7, 5'd31, 5'd31, 5'd31, 1'b0, 6'h3F, 3'd0, 2'd0, 1'b0,
                   3'd0, 11'h000, 10'h000, 2'd0);
    vecs[5].exp = 32'hFDFFFFD7;
    vecs[6].b = mk(2'd2, 7'h57, 3'd0, 5'd2, 5'd1, 5'd0, 1'b0, 6'h00, 3'd0, 2'd0, 1'b0,
                   3'd0, 11'h7FF, 10'h155, 2'd1);
    vecs[6].exp = 32'h7FF0F157;
    vecs[7].b = mk(2'd1, 7'h27, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 6'h00, 3'd0, 2'd3, 1'b1,
                   3'd7, 11'h000, 10'h000, 2'd0);
    vecs[7].exp = 32'hFC000027;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cur = rand_bundle(2'd0, 0);
    exp_out = 32'h0; exp_err = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;
    cycle("post_reset");

    // Encoding table: push into empty queue, visible next cycle, then pop
    for (int i = 0; i < 8; i++) begin
      cur = vecs[i].b; in_valid = 1'b1; out_ready = 1'b0;
      cycle("vec_push");
      chk($sformatf("vec%0d.word", i), insn_out, vecs[i].exp);
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      cycle("vec_pop");
    end
    out_ready = 1'b0;

    // Fill to DEPTH, stalled bundle (even an illegal one) is ignored silently
    for (int i = 0; i < 4; i++) begin
      cur = rand_bundle(2'd0, 0); in_valid = 1'b1;
      pushed[i] = ref_enc(cur);
      cycle("fill");
    end
    chk("full.count", 32'(count), 32'd4);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    cur = rand_bundle(2'd3, 0);
    cycle("stall");
    chk("stall.count", 32'(count), 32'd4);
    chk("stall.err", 32'(err), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d.word", i), insn_out, pushed[i]);
      cycle("drain");
    end
    chk("drained.valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Rejected bundle: count unchanged, err high exactly one cycle
    cur = rand_bundle(2'd1, 1); in_valid = 1'b1;
    cycle("rej_pre");
    cur = rand_bundle(2'd3, 0);
    cycle("rej");
    chk("rej.err", 32'(err), 32'd1);
    chk("rej.count", 32'(count), 32'd1);
    in_valid = 1'b0;
    cycle("rej_after");
    chk("rej_after.err", 32'(err), 32'd0);
`ifdef INSN_ENC_CHECK_EN
    cur = rand_bundle(2'd0, 1); in_valid = 1'b1;
    cycle("badopc");
    chk("badopc.err", 32'(err), 32'd1);
    chk("badopc.count", 32'(count), 32'd1);
    in_valid = 1'b0;
    cycle("badopc_after");
    chk("badopc_after.err", 32'(err), 32'd0);
`endif
    out_ready = 1'b1;
    cycle("rej_drain");
    out_ready = 1'b0;

    // Steady streaming at count=2 with pointer wrap
    for (int i = 0; i < 2; i++) begin
      cur = rand_bundle(2'd0, 0); in_valid = 1'b1;
      cycle("stream_pre");
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cur = rand_bundle(2'(i % 3), 0);
      if (i % 3 == 1) cur.mjr = 7'h27;
      cycle("stream");
      chk("stream.count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    repeat (2) cycle("stream_drain");
    out_ready = 1'b0;

    // Asynchronous reset with three words queued
    for (int i = 0; i < 3; i++) begin
      cur = rand_bundle(2'd0, 0); in_valid = 1'b1;
      cycle("prerst");
    end
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    mq.delete(); exp_out = 32'h0; exp_err = 1'b0;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.count", 32'(count), 32'd0);
    check_all("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle("rst_release");
    chk("rst_release.in_ready", 32'(in_ready), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cur = rand_bundle(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
